// File: rtl/alu_issue.sv
// Issue/retire sequencer around the core0 ALU: S1 issue register, S2 result register, C/O flags.
// Define ALU_ISSUE_SKID_EN to add a one-entry skid buffer ahead of S1 with a registered in_ready.
module alu_issue #(
   parameter  int unsigned WIDTH_MAG = 5,
   localparam int unsigned WIDTH     = 1 << WIDTH_MAG
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_opcode,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_use_c,
   input  logic             in_clr_f,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_ic,
   output logic [2:0]       alu_opcode,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_oc,
   input  logic             alu_oo,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             flag_c,
   output logic             flag_o
);

   localparam logic [2:0] OP_ADD = 3'd7;

   typedef struct packed {
      logic [2:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             use_c;
      logic             clr_f;
   } cmd_t;

   cmd_t             in_cmd;
   cmd_t             s1_q, s1_d;
   logic             v1_q, v1_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             flag_c_q, flag_c_d;
   logic             flag_o_q, flag_o_d;
   logic             advance;
   logic             s1_free;
   logic             accept;

   assign in_cmd  = {in_opcode, in_a, in_b, in_use_c, in_clr_f};
   assign advance = v1_q && (!out_valid_q || out_ready);
   assign s1_free = !v1_q || advance;

   // clr_f takes effect before the carry is consumed, so the issuing command never sees the old C.
   assign alu_a      = s1_q.a;
   assign alu_b      = s1_q.b;
   assign alu_opcode = s1_q.op;
   assign alu_ic     = s1_q.use_c & ~s1_q.clr_f & flag_c_q;

`ifdef ALU_ISSUE_SKID_EN
   cmd_t skid_q, skid_d;
   logic skid_v_q, skid_v_d;

   assign in_ready = !skid_v_q;
   assign accept   = in_valid && in_ready;

   // A parked command always refills S1 before new input, which keeps strict order.
   always_comb begin
      s1_d     = s1_q;
      v1_d     = v1_q && !advance;
      skid_d   = skid_q;
      skid_v_d = skid_v_q;
      if (s1_free) begin
         if (skid_v_q) begin
            s1_d     = skid_q;
            v1_d     = 1'b1;
            skid_v_d = 1'b0;
         end else if (accept) begin
            s1_d = in_cmd;
            v1_d = 1'b1;
         end
      end else if (accept) begin
         skid_d   = in_cmd;
         skid_v_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         skid_q   <= '0;
         skid_v_q <= 1'b0;
      end else begin
         skid_q   <= skid_d;
         skid_v_q <= skid_v_d;
      end
   end
`else
   assign in_ready = s1_free;
   assign accept   = in_valid && in_ready;

   always_comb begin
      s1_d = s1_q;
      v1_d = v1_q && !advance;
      if (accept) begin
         s1_d = in_cmd;
         v1_d = 1'b1;
      end
   end
`endif

   always_comb begin
      flag_c_d    = flag_c_q;
      flag_o_d    = flag_o_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q && !out_ready;
      if (advance) begin
         out_valid_d = 1'b1;
         out_data_d  = alu_out;
         if (s1_q.op == OP_ADD) begin
            flag_c_d = alu_oc;
            flag_o_d = alu_oo;
         end else if (s1_q.clr_f) begin
            flag_c_d = 1'b0;
            flag_o_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q        <= '0;
         v1_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         flag_c_q    <= 1'b0;
         flag_o_q    <= 1'b0;
      end else begin
         s1_q        <= s1_d;
         v1_q        <= v1_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         flag_c_q    <= flag_c_d;
         flag_o_q    <= flag_o_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign flag_c    = flag_c_q;
   assign flag_o    = flag_o_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue with a behavioural ALU closing the loop.
// Expected accept count under backpressure depends on ALU_ISSUE_SKID_EN.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_opcode;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        in_use_c;
   logic        in_clr_f;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic        alu_ic;
   logic [2:0]  alu_opcode;
   logic [31:0] alu_out;
   logic        alu_oc;
   logic        alu_oo;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        flag_c;
   logic        flag_o;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] STREAM_EXP [8] = '{
      32'h0100_0000, 32'h0200_0001, 32'h0300_0002, 32'h0400_0003,
      32'h0500_0004, 32'h0600_0005, 32'h0700_0006, 32'h0800_0007
   };
   localparam logic [31:0] BP_EXP [3] = '{32'h0000_0002, 32'h0000_0004, 32'h0000_0008};
`ifdef ALU_ISSUE_SKID_EN
   localparam int BP_ACCEPTS = 3;
`else
   localparam int BP_ACCEPTS = 2;
`endif

   alu_issue #(.WIDTH_MAG(5)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
      .in_a(in_a), .in_b(in_b), .in_use_c(in_use_c), .in_clr_f(in_clr_f),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ic(alu_ic), .alu_opcode(alu_opcode),
      .alu_out(alu_out), .alu_oc(alu_oc), .alu_oo(alu_oo),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .flag_c(flag_c), .flag_o(flag_o)
   );

   always #5 clk = ~clk;

   // Reference ALU; non-add opcodes drive oc/oo low so stray flag writes become visible.
   logic [4:0]  sh;
   logic [32:0] sum;
   always_comb begin
      sh      = alu_b[4:0];
      sum     = {1'b0, alu_a} + {1'b0, alu_b} + {32'b0, alu_ic};
      alu_out = '0;
      alu_oc  = 1'b0;
      alu_oo  = 1'b0;
      case (alu_opcode)
         3'd0: alu_out = alu_a << sh;
         3'd1: alu_out = alu_a >> sh;
         3'd2: alu_out = (alu_a << sh) | (alu_a >> (6'd32 - {1'b0, sh}));
         3'd3: alu_out = (alu_a >> sh) | (alu_a << (6'd32 - {1'b0, sh}));
         3'd4: alu_out = $signed(alu_a) >>> sh;
         3'd5: alu_out = alu_a & alu_b;
         3'd6: alu_out = alu_a | alu_b;
         default: begin
            alu_out = sum[31:0];
            alu_oc  = sum[32];
            alu_oo  = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
         end
      endcase
   end

   task automatic set_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic uc, input logic cf);
      in_opcode = op;
      in_a      = a;
      in_b      = b;
      in_use_c  = uc;
      in_clr_f  = cf;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic send_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic uc, input logic cf, output logic ok);
      set_cmd(op, a, b, uc, cf);
      in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         #1;
         if (in_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (out_valid) ok = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      set_cmd(3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      checks++; if ({flag_c, flag_o} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", flag_c, flag_o); end
      checks++; if ({alu_a, alu_b, alu_ic, alu_opcode} !== 68'h0) begin errors++; $display("FAIL reset_alu a=%h b=%h ic=%b op=%0d exp all 0", alu_a, alu_b, alu_ic, alu_opcode); end
      reset = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      @(posedge clk); #1;
      $display("test_reset done");
   endtask

   task automatic test_add_adc();
      out_ready = 1'b1;
      set_cmd(3'd7, 32'h8000_1000, 32'h8000_8000, 1'b0, 1'b0);
      in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got=%b exp=1", in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency out_valid got=%b exp=0", out_valid); end
      checks++; if (alu_a !== 32'h8000_1000 || alu_opcode !== 3'd7) begin errors++; $display("FAIL add_issue alu_a=%h op=%0d exp=80001000/7", alu_a, alu_opcode); end
      set_cmd(3'd7, 32'h1, 32'h1, 1'b1, 1'b0);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL adc_in_ready got=%b exp=1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_9000) begin errors++; $display("FAIL add_result valid=%b data=%h exp=1/00009000", out_valid, out_data); end
      checks++; if ({flag_c, flag_o} !== 2'b11) begin errors++; $display("FAIL add_flags got=%b%b exp=11", flag_c, flag_o); end
      checks++; if (alu_ic !== 1'b1) begin errors++; $display("FAIL adc_alu_ic got=%b exp=1", alu_ic); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h3) begin errors++; $display("FAIL adc_result valid=%b data=%h exp=1/00000003", out_valid, out_data); end
      checks++; if ({flag_c, flag_o} !== 2'b00) begin errors++; $display("FAIL adc_flags got=%b%b exp=00", flag_c, flag_o); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain out_valid got=%b exp=0", out_valid); end
      $display("test_add_adc done");
   endtask

   task automatic test_clr_flags();
      logic ok_s, ok_r;
      out_ready = 1'b1;
      send_cmd(3'd7, 32'h8000_1000, 32'h8000_8000, 1'b0, 1'b0, ok_s); wait_out(ok_r);
      checks++; if (!ok_s || !ok_r || {flag_c, flag_o} !== 2'b11) begin errors++; $display("FAIL clr_setup flags=%b%b handshake=%b%b exp=11/11", flag_c, flag_o, ok_s, ok_r); end
      @(posedge clk); #1;
      send_cmd(3'd3, 32'h8000_9001, 32'h1, 1'b0, 1'b0, ok_s); wait_out(ok_r);
      checks++; if (!ok_s || !ok_r || out_data !== 32'hC000_4800) begin errors++; $display("FAIL csr_data got=%h exp=c0004800", out_data); end
      checks++; if ({flag_c, flag_o} !== 2'b11) begin errors++; $display("FAIL csr_keep_flags got=%b%b exp=11", flag_c, flag_o); end
      @(posedge clk); #1;
      send_cmd(3'd3, 32'h8000_9001, 32'h1, 1'b0, 1'b1, ok_s); wait_out(ok_r);
      checks++; if (!ok_s || !ok_r || out_data !== 32'hC000_4800) begin errors++; $display("FAIL csr_clr_data got=%h exp=c0004800", out_data); end
      checks++; if ({flag_c, flag_o} !== 2'b00) begin errors++; $display("FAIL csr_clr_flags got=%b%b exp=00", flag_c, flag_o); end
      @(posedge clk); #1;
      send_cmd(3'd7, 32'h8000_1000, 32'h8000_8000, 1'b0, 1'b0, ok_s); wait_out(ok_r);
      @(posedge clk); #1;
      send_cmd(3'd7, 32'h1, 32'h1, 1'b1, 1'b1, ok_s); wait_out(ok_r);
      checks++; if (!ok_s || !ok_r || out_data !== 32'h2) begin errors++; $display("FAIL adc_clr_data got=%h exp=00000002", out_data); end
      checks++; if ({flag_c, flag_o} !== 2'b00) begin errors++; $display("FAIL adc_clr_flags got=%b%b exp=00", flag_c, flag_o); end
      @(posedge clk); #1;
      $display("test_clr_flags done");
   endtask

   task automatic test_stream();
      int sent = 0, rcv = 0, cyc = 0;
      logic acc, stalled = 1'b0;
      logic [31:0] held = '0;
      while (rcv < 8 && cyc < 100) begin
         in_valid = (sent < 8);
         set_cmd(3'd7, 32'h0100_0000 * (sent + 1), 32'(sent), 1'b0, 1'b0);
         out_ready = (cyc % 3 == 0);
         #1;
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held) begin errors++; $display("FAIL stream_stable got=%b/%h exp=1/%h", out_valid, out_data, held); end
         end
         acc = in_valid && in_ready;
         if (out_valid && out_ready) begin
            checks++;
            if (out_data !== STREAM_EXP[rcv]) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", rcv, out_data, STREAM_EXP[rcv]); end
            rcv++;
         end
         stalled = out_valid && !out_ready;
         held    = out_data;
         @(posedge clk); #1;
         if (acc) sent++;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (rcv != 8 || sent != 8) begin errors++; $display("FAIL stream_count sent=%0d rcv=%0d exp=8/8", sent, rcv); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_duplicate out_valid got=%b exp=0", out_valid); end
      $display("test_stream done");
   endtask

   task automatic test_reset_inflight();
      logic ok_s;
      int stale = 0;
      do_reset();
      out_ready = 1'b0;
      send_cmd(3'd7, 32'h8000_1000, 32'h8000_8000, 1'b0, 1'b0, ok_s);
      send_cmd(3'd0, 32'h1, 32'h4, 1'b0, 1'b0, ok_s);
      checks++; if (out_valid !== 1'b1 || flag_c !== 1'b1) begin errors++; $display("FAIL inflight_setup valid=%b c=%b exp=1/1", out_valid, flag_c); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL inflight_reset_out valid=%b data=%h exp=0/0", out_valid, out_data); end
      checks++; if ({flag_c, flag_o} !== 2'b00) begin errors++; $display("FAIL inflight_reset_flags got=%b%b exp=00", flag_c, flag_o); end
      checks++; if (alu_a !== 32'h0 || alu_opcode !== 3'd0) begin errors++; $display("FAIL inflight_reset_alu a=%h op=%0d exp=0/0", alu_a, alu_opcode); end
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (out_valid) stale++;
         @(posedge clk); #1;
      end
      checks++; if (stale != 0) begin errors++; $display("FAIL inflight_stale got=%0d results exp=0", stale); end
      $display("test_reset_inflight done");
   endtask

   task automatic test_backpressure();
      int acc = 0, rcv = 0;
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_cmd(3'd0, 32'h1, 32'(acc + 1), 1'b0, 1'b0);
         #1;
         if (in_ready) acc++;
         @(posedge clk); #1;
      end
      set_cmd(3'd0, 32'h1, 32'(acc + 1), 1'b0, 1'b0);
      #1;
      checks++; if (acc != BP_ACCEPTS) begin errors++; $display("FAIL bp_accepts got=%0d exp=%0d", acc, BP_ACCEPTS); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && rcv < BP_ACCEPTS; i++) begin
         if (out_valid) begin
            checks++;
            if (out_data !== BP_EXP[rcv]) begin errors++; $display("FAIL bp_data[%0d] got=%h exp=%h", rcv, out_data, BP_EXP[rcv]); end
            rcv++;
         end
         @(posedge clk); #1;
      end
      checks++; if (rcv != BP_ACCEPTS) begin errors++; $display("FAIL bp_drain got=%0d exp=%0d", rcv, BP_ACCEPTS); end
      $display("test_backpressure done accepts=%0d", acc);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      set_cmd(3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      test_reset();
      test_add_adc();
      test_clr_flags();
      test_stream();
      test_reset_inflight();
      test_backpressure();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
